// File: rtl/branch_pkg.sv
// Shared types for the fetch predictor: branch kinds, counter encodings and
// the 2-bit saturating counter step.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_COND = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_type_e;

    localparam logic [1:0] CNT_WEAK_NT = 2'b01;
    localparam logic [1:0] CNT_WEAK_T  = 2'b10;

    function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a speculative copy driven by predictions and a
// committed copy driven by resolved branches, which repairs the speculative one.
module return_addr_stack #(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic                  commit_push,
    input  logic                  commit_pop,
    input  logic [ADDR_WIDTH-1:0] commit_addr,
    input  logic                  restore,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  empty
);

    localparam int PTR_BITS = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_BITS = $clog2(RAS_DEPTH + 1);

    typedef logic [PTR_BITS-1:0]   ptr_t;
    typedef logic [CNT_BITS-1:0]   cnt_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(RAS_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    function automatic ptr_t ptr_dec(input ptr_t p);
        return (p == '0) ? ptr_t'(RAS_DEPTH - 1) : p - ptr_t'(1);
    endfunction

    addr_t spec_mem [RAS_DEPTH];
    addr_t com_mem  [RAS_DEPTH];
    addr_t com_mem_n[RAS_DEPTH];
    ptr_t  spec_ptr, com_ptr, com_ptr_n;
    cnt_t  spec_cnt, com_cnt, com_cnt_n;

    // Committed next state is computed separately so a repair can copy the
    // committed stack including this cycle's resolved call/return.
    always_comb begin
        com_mem_n = com_mem;
        com_ptr_n = com_ptr;
        com_cnt_n = com_cnt;
        if (commit_push) begin
            com_mem_n[com_ptr] = commit_addr;
            com_ptr_n          = ptr_inc(com_ptr);
            com_cnt_n          = (com_cnt == cnt_t'(RAS_DEPTH)) ? com_cnt : com_cnt + cnt_t'(1);
        end else if (commit_pop && com_cnt != '0) begin
            com_ptr_n = ptr_dec(com_ptr);
            com_cnt_n = com_cnt - cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                spec_mem[i] <= '0;
                com_mem[i]  <= '0;
            end
            spec_ptr <= '0;
            spec_cnt <= '0;
            com_ptr  <= '0;
            com_cnt  <= '0;
        end else begin
            com_mem <= com_mem_n;
            com_ptr <= com_ptr_n;
            com_cnt <= com_cnt_n;
            if (restore) begin
                spec_mem <= com_mem_n;
                spec_ptr <= com_ptr_n;
                spec_cnt <= com_cnt_n;
            end else if (push) begin
                spec_mem[spec_ptr] <= push_addr;
                spec_ptr           <= ptr_inc(spec_ptr);
                spec_cnt           <= (spec_cnt == cnt_t'(RAS_DEPTH)) ? spec_cnt : spec_cnt + cnt_t'(1);
            end else if (pop && spec_cnt != '0) begin
                spec_ptr <= ptr_dec(spec_ptr);
                spec_cnt <= spec_cnt - cnt_t'(1);
            end
        end
    end

    assign top   = spec_mem[ptr_dec(spec_ptr)];
    assign empty = (spec_cnt == '0);

endmodule

// File: rtl/branch_predictor_nway.sv
// Fetch-group predictor: one tagged BTB bank per slot with 2-bit counters,
// lowest-slot priority select, and call/return prediction through the RAS.
module branch_predictor_nway
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int FETCH_WIDTH = 2,
    parameter int ENTRY_NUM   = 64,
    parameter int TAG_WIDTH   = 12,
    parameter int RAS_DEPTH   = 8,
    localparam int SLOT_BITS  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ifVld,
    input  logic [ADDR_WIDTH-1:0] ifPC,
    output logic                  pdVld,
    output logic                  pdBranch,
    output logic [SLOT_BITS-1:0]  pdSlot,
    output logic [ADDR_WIDTH-1:0] pdPC,
    input  logic                  exVld,
    input  logic [ADDR_WIDTH-1:0] exPC,
    input  logic [ADDR_WIDTH-1:0] exPCTar,
    input  logic [1:0]            exType,
    input  logic                  exBranch,
    input  logic                  exWrong
);

    localparam int INDEX_BITS = $clog2(ENTRY_NUM);
    localparam int TAG_LSB    = 2 + SLOT_BITS + INDEX_BITS;

    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        br_type_e              btype;
        logic [ADDR_WIDTH-1:0] target;
        logic [1:0]            cnt;
    } entry_t;

    entry_t btb [FETCH_WIDTH][ENTRY_NUM];

    logic [SLOT_BITS-1:0]  if_off, hit_slot;
    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_WIDTH-1:0]  if_tag;
    logic [ADDR_WIDTH-1:0] if_base, hit_target, next_pc, ras_top;
    br_type_e              hit_type;
    logic                  hit_found, lookup_go, ras_empty;

    assign if_off    = ifPC[2 +: SLOT_BITS];
    assign if_idx    = ifPC[2 + SLOT_BITS +: INDEX_BITS];
    assign if_tag    = ifPC[TAG_LSB +: TAG_WIDTH];
    assign if_base   = {ifPC[ADDR_WIDTH-1:2+SLOT_BITS], {(2 + SLOT_BITS){1'b0}}};
    assign lookup_go = ifVld && !exWrong;

    // NOTE: always_comb uses blocking assignments with every output defaulted
    // first, so the priority loop builds no latches.
    always_comb begin
        entry_t e;
        logic   take;
        hit_found  = 1'b0;
        hit_slot   = '0;
        hit_type   = BR_NONE;
        hit_target = '0;
        for (int s = 0; s < FETCH_WIDTH; s++) begin
            e    = btb[s][if_idx];
            take = 1'b0;
            if (SLOT_BITS'(s) >= if_off && e.valid && e.tag == if_tag) begin
                unique case (e.btype)
                    BR_COND: take = e.cnt[1];
                    BR_CALL: take = 1'b1;
                    BR_RET:  take = !ras_empty;
                    default: take = 1'b0;
                endcase
            end
            if (take && !hit_found) begin
                hit_found  = 1'b1;
                hit_slot   = SLOT_BITS'(s);
                hit_type   = e.btype;
                hit_target = e.target;
            end
        end
    end

    always_comb begin
        next_pc = if_base + ADDR_WIDTH'(4 * FETCH_WIDTH);
        if (hit_found)
            next_pc = (hit_type == BR_RET) ? ras_top : hit_target;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pdVld    <= 1'b0;
            pdBranch <= 1'b0;
            pdSlot   <= '0;
            pdPC     <= '0;
        end else begin
            pdVld <= lookup_go;
            if (lookup_go) begin
                pdBranch <= hit_found;
                pdSlot   <= hit_slot;
                pdPC     <= next_pc;
            end else begin
                pdBranch <= 1'b0;
                pdSlot   <= '0;
            end
        end
    end

    // Resolved-branch update of the owning bank.
    logic [SLOT_BITS-1:0]  ex_bank;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_WIDTH-1:0]  ex_tag;
    br_type_e              ex_type;
    entry_t                ex_old, ex_new;
    logic                  ex_hit, btb_we;

    assign ex_bank = exPC[2 +: SLOT_BITS];
    assign ex_idx  = exPC[2 + SLOT_BITS +: INDEX_BITS];
    assign ex_tag  = exPC[TAG_LSB +: TAG_WIDTH];
    assign ex_type = br_type_e'(exType);
    assign ex_old  = btb[ex_bank][ex_idx];
    assign ex_hit  = ex_old.valid && ex_old.tag == ex_tag;
    assign btb_we  = exVld && ex_type != BR_NONE;

    always_comb begin
        ex_new.valid  = 1'b1;
        ex_new.tag    = ex_tag;
        ex_new.btype  = ex_type;
        ex_new.target = exPCTar;
        ex_new.cnt    = exBranch ? CNT_WEAK_T : CNT_WEAK_NT;
        if (ex_hit) begin
            ex_new.cnt = cnt_step(ex_old.cnt, exBranch);
            if (ex_type == BR_COND && !exBranch)
                ex_new.target = ex_old.target;
        end
    end

    // NOTE: the BTB is reset in full because valid bits and counters must come
    // up in a known state; a RAM macro would need a separate valid/counter array.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < FETCH_WIDTH; b++)
                for (int i = 0; i < ENTRY_NUM; i++)
                    btb[b][i] <= '{valid: 1'b0, tag: '0, btype: BR_NONE, target: '0, cnt: CNT_WEAK_NT};
        end else if (btb_we) begin
            btb[ex_bank][ex_idx] <= ex_new;
        end
    end

    return_addr_stack #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .rstn       (rstn),
        .push       (lookup_go && hit_found && hit_type == BR_CALL),
        .pop        (lookup_go && hit_found && hit_type == BR_RET),
        .push_addr  (if_base + ADDR_WIDTH'({hit_slot, 2'b00}) + ADDR_WIDTH'(4)),
        .commit_push(exVld && exBranch && ex_type == BR_CALL),
        .commit_pop (exVld && exBranch && ex_type == BR_RET),
        .commit_addr(exPC + ADDR_WIDTH'(4)),
        .restore    (exWrong),
        .top        (ras_top),
        .empty      (ras_empty)
    );

    logic unused_bits;
    assign unused_bits = ^{ifPC, exPC, ex_old.btype};

endmodule

// File: tb/tb_branch_predictor_nway.sv
// Directed bench for branch_predictor_nway (FETCH_WIDTH=2, 64 entries, 12-bit tag, 8-deep RAS).
module tb_branch_predictor_nway;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ifVld;
    logic [31:0] ifPC;
    logic        pdVld, pdBranch;
    logic [0:0]  pdSlot;
    logic [31:0] pdPC;
    logic        exVld;
    logic [31:0] exPC, exPCTar;
    logic [1:0]  exType;
    logic        exBranch, exWrong;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor_nway #(
        .ADDR_WIDTH (32),
        .FETCH_WIDTH(2),
        .ENTRY_NUM  (64),
        .TAG_WIDTH  (12),
        .RAS_DEPTH  (8)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .ifVld   (ifVld),
        .ifPC    (ifPC),
        .pdVld   (pdVld),
        .pdBranch(pdBranch),
        .pdSlot  (pdSlot),
        .pdPC    (pdPC),
        .exVld   (exVld),
        .exPC    (exPC),
        .exPCTar (exPCTar),
        .exType  (exType),
        .exBranch(exBranch),
        .exWrong (exWrong)
    );

    typedef struct {
        logic        if_vld;
        logic [31:0] if_pc;
        logic        ex_vld;
        logic [31:0] ex_pc;
        logic [31:0] ex_tar;
        logic [1:0]  ex_type;
        logic        ex_br;
        logic        exp_vld;
        logic        exp_br;
        logic        exp_slot;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [31:0] ipc, input logic ev,
                                input logic [31:0] epc, input logic [31:0] etar, input logic [1:0] ety,
                                input logic ebr, input logic xv, input logic xb, input logic xs,
                                input logic [31:0] xpc);
        vec_t v;
        v.if_vld = iv;  v.if_pc = ipc;  v.ex_vld = ev;  v.ex_pc = epc;  v.ex_tar = etar;
        v.ex_type = ety; v.ex_br = ebr; v.exp_vld = xv; v.exp_br = xb;  v.exp_slot = xs;
        v.exp_pc = xpc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ipc, input logic ev, input logic [31:0] epc,
                         input logic [31:0] etar, input logic [1:0] ety, input logic ebr, input logic wr);
        ifVld = iv; ifPC = ipc; exVld = ev; exPC = epc; exPCTar = etar;
        exType = ety; exBranch = ebr; exWrong = wr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup_check(input string name, input logic [31:0] pc, input logic xb,
                                input logic [31:0] xpc);
        drive(1'b1, pc, 1'b0, '0, '0, BR_NONE, 1'b0, 1'b0);
        step();
        check({name, ".vld"}, 32'(pdVld), 32'd1);
        check({name, ".br"}, 32'(pdBranch), 32'(xb));
        check({name, ".pc"}, pdPC, xpc);
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = mk(1, 32'h1000, 0, 0, 0, BR_NONE, 0, 1, 0, 0, 32'h1008);
        vecs[1]  = mk(1, 32'h1000, 1, 32'h1004, 32'h2000, BR_COND, 1, 1, 0, 0, 32'h1008);
        vecs[2]  = mk(1, 32'h1000, 1, 32'h1004, 32'h2000, BR_COND, 1, 1, 1, 1, 32'h2000);
        vecs[3]  = mk(1, 32'h1000, 1, 32'h1004, 32'h2000, BR_COND, 0, 1, 1, 1, 32'h2000);
        vecs[4]  = mk(1, 32'h1000, 1, 32'h1004, 32'h2000, BR_COND, 0, 1, 1, 1, 32'h2000);
        vecs[5]  = mk(1, 32'h1000, 0, 0, 0, BR_NONE, 0, 1, 0, 0, 32'h1008);
        vecs[6]  = mk(0, 32'h0,    0, 0, 0, BR_NONE, 0, 0, 0, 0, 32'h0);
        vecs[7]  = mk(1, 32'h3004, 1, 32'h3000, 32'h5000, BR_CALL, 1, 1, 0, 0, 32'h3008);
        vecs[8]  = mk(1, 32'h3004, 0, 0, 0, BR_NONE, 0, 1, 0, 0, 32'h3008);
        vecs[9]  = mk(1, 32'h3000, 1, 32'h6000, 32'h0, BR_RET, 1, 1, 1, 0, 32'h5000);
        vecs[10] = mk(1, 32'h6000, 0, 0, 0, BR_NONE, 0, 1, 1, 0, 32'h3004);
        vecs[11] = mk(1, 32'h6000, 0, 0, 0, BR_NONE, 0, 1, 0, 0, 32'h6008);
        vecs[12] = mk(1, 32'hFFFF_FFFC, 0, 0, 0, BR_NONE, 0, 1, 0, 0, 32'h0);
        vecs[13] = mk(1, 32'h7028, 1, 32'h7028, 32'h8000, BR_COND, 0, 1, 0, 0, 32'h7030);
        vecs[14] = mk(1, 32'h7028, 1, 32'h7028, 32'h8000, BR_COND, 1, 1, 0, 0, 32'h7030);
        vecs[15] = mk(1, 32'h7028, 0, 0, 0, BR_NONE, 0, 1, 1, 0, 32'h8000);

        rstn = 1'b0;
        drive(1'b0, '0, 1'b0, '0, '0, BR_NONE, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset.vld", 32'(pdVld), 32'd0);
        check("reset.br", 32'(pdBranch), 32'd0);
        check("reset.slot", 32'(pdSlot), 32'd0);
        check("reset.pc", pdPC, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].if_vld, vecs[i].if_pc, vecs[i].ex_vld, vecs[i].ex_pc, vecs[i].ex_tar,
                  vecs[i].ex_type, vecs[i].ex_br, 1'b0);
            step();
            check($sformatf("vec%0d.vld", i), 32'(pdVld), 32'(vecs[i].exp_vld));
            check($sformatf("vec%0d.br", i), 32'(pdBranch), 32'(vecs[i].exp_br));
            check($sformatf("vec%0d.slot", i), 32'(pdSlot), 32'(vecs[i].exp_slot));
            if (vecs[i].exp_vld)
                check($sformatf("vec%0d.pc", i), pdPC, vecs[i].exp_pc);
        end

        // Nine calls overflow the 8-deep speculative stack; returns unwind newest first.
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, '0, 1'b1, 32'h4040 + 32'(8 * k), 32'h9000 + 32'(256 * k), BR_CALL, 1'b1, 1'b0);
            step();
        end
        for (int k = 0; k < 9; k++)
            lookup_check($sformatf("call%0d", k), 32'h4040 + 32'(8 * k), 1'b1, 32'h9000 + 32'(256 * k));
        for (int k = 0; k < 9; k++) begin
            if (k < 8)
                lookup_check($sformatf("ret%0d", k), 32'h6000, 1'b1, 32'h4044 + 32'(8 * (8 - k)));
            else
                lookup_check($sformatf("ret%0d", k), 32'h6000, 1'b0, 32'h6008);
        end

        // Drain the committed stack, speculate three calls, then redirect.
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, '0, 1'b1, 32'h6000, 32'h0, BR_RET, 1'b1, 1'b0);
            step();
        end
        for (int k = 0; k < 3; k++)
            lookup_check($sformatf("spec%0d", k), 32'h4040 + 32'(8 * k), 1'b1, 32'h9000 + 32'(256 * k));
        drive(1'b1, 32'h4058, 1'b0, '0, '0, BR_NONE, 1'b0, 1'b1);
        step();
        check("wrong.vld", 32'(pdVld), 32'd0);
        lookup_check("repair.ret", 32'h6000, 1'b0, 32'h6008);

        // Asynchronous reset mid-cycle wipes the trained index-5 entry.
        drive(1'b0, '0, 1'b0, '0, '0, BR_NONE, 1'b0, 1'b0);
        rstn = 1'b0;
        #2;
        check("areset.pc", pdPC, 32'd0);
        check("areset.vld", 32'(pdVld), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        lookup_check("post_reset", 32'h7028, 1'b0, 32'h7030);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
